// File: rtl/ram32x4_scan_ctrl_pkg.sv
// ram32x4_pkg: shared widths, depth and FSM state type for the 32x4 RAM sequencer.
package ram32x4_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 32;
    typedef enum logic [1:0] {CLEAR, SCAN, WRITE} state_t;
endpackage

// File: rtl/ram32x4_scan_ctrl_tick_divider.sv
// tick_divider: one-cycle tick every TICK_DIV enabled cycles; the count holds while en is low.
module tick_divider #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    logic [CW-1:0] cnt_q;
    assign tick = en && (cnt_q == CW'(TICK_DIV - 1));
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (en)
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
endmodule

// File: rtl/ram32x4_scan_ctrl.sv
// ram32x4_scan_ctrl: clears the RAM after reset, then scans read addresses and injects edge-triggered writes.
module ram32x4_scan_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int ADDR_W   = ram32x4_pkg::ADDR_W,
    parameter int DATA_W   = ram32x4_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              busy
);
    import ram32x4_pkg::*;
    state_t            state_q;
    logic [ADDR_W:0]   clr_cnt_q;
    logic [ADDR_W-1:0] scan_q, scan_d;
    logic              wr_req_q, pend_wr_q, pend_tick_q, tick, wr_edge;
    assign wr_edge = wr_req & ~wr_req_q;
    // a tick deferred by a write is applied together with the WRITE->SCAN step
    assign scan_d  = scan_q + ADDR_W'(tick | pend_tick_q);
    tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
        .clk(clk),
        .reset(reset),
        .en(run && (state_q != CLEAR)),
        .tick(tick)
    );
    // state_q always names the kind of cycle currently driven on the RAM outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            scan_q      <= '0;
            wr_req_q    <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_tick_q <= 1'b0;
            ram_addr    <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            rd_addr     <= '0;
            rd_valid    <= 1'b0;
            busy        <= 1'b1;
        end else begin
            wr_req_q  <= wr_req;
            rd_addr   <= ram_addr;
            rd_valid  <= (state_q == SCAN) && !ram_wren;
            pend_wr_q <= pend_wr_q | wr_edge;
            case (state_q)
                CLEAR: begin
                    ram_data <= '0;
                    if (clr_cnt_q[ADDR_W]) begin
                        state_q  <= SCAN;
                        ram_addr <= scan_q;
                        ram_wren <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        ram_addr  <= clr_cnt_q[ADDR_W-1:0];
                        ram_wren  <= 1'b1;
                        busy      <= 1'b1;
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                SCAN: begin
                    if (pend_wr_q) begin
                        state_q     <= WRITE;
                        pend_wr_q   <= 1'b0;
                        pend_tick_q <= tick;
                        ram_addr    <= wr_addr;
                        ram_data    <= wr_data;
                        ram_wren    <= 1'b1;
                        busy        <= 1'b1;
                    end else begin
                        scan_q   <= scan_d;
                        ram_addr <= scan_d;
                        ram_data <= '0;
                        ram_wren <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= SCAN;
                    scan_q      <= scan_d;
                    pend_tick_q <= 1'b0;
                    ram_addr    <= scan_d;
                    ram_data    <= '0;
                    ram_wren    <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram32x4_scan_ctrl.sv
// tb_ram32x4_scan_ctrl: scenario tasks checking the sequencer against a cycle-count scan model.
module tb_ram32x4_scan_ctrl;
    localparam int TD = 4;
    logic       clk = 1'b0, reset = 1'b1, run = 1'b0, wr_req = 1'b0;
    logic [4:0] wr_addr = '0, ram_addr, rd_addr;
    logic [3:0] wr_data = '0, ram_data;
    logic       ram_wren, rd_valid, busy;
    int         n_chk = 0, n_fail = 0, cyc = 0, e = 0;

    ram32x4_scan_ctrl #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .run(run), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
        .rd_addr(rd_addr), .rd_valid(rd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // scan address = completed ticks mod 32, ticks = enabled SCAN-phase cycles / TICK_DIV
    function automatic logic [4:0] exp_scan();
        return 5'((e / TD) % 32);
    endfunction

    task automatic step();
        if (run && cyc >= 33) e++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        e = 0;
    endtask

    task automatic test_reset();
        run = 1'b0;
        do_reset();
        n_chk++;
        if ({ram_wren, ram_data, ram_addr, rd_addr, rd_valid, busy} !== {1'b0, 4'h0, 5'h0, 5'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values got wren=%b data=%h addr=%h rd=%h v=%b busy=%b", ram_wren, ram_data, ram_addr, rd_addr, rd_valid, busy);
        end
        for (int i = 0; i < 32; i++) begin
            step();
            n_chk++;
            if ({ram_wren, ram_data, ram_addr, busy, rd_valid, rd_addr} !== {1'b1, 4'h0, 5'(i), 1'b1, 1'b0, 5'(i == 0 ? 0 : i - 1)}) begin
                n_fail++;
                $display("FAIL clear_cycle c=%0d got wren=%b data=%h addr=%h busy=%b v=%b rd=%h exp addr=%h", cyc, ram_wren, ram_data, ram_addr, busy, rd_valid, rd_addr, 5'(i));
            end
        end
        step();
        n_chk++;
        if ({ram_wren, busy, ram_addr, rd_addr, rd_valid} !== {1'b0, 1'b0, 5'h0, 5'h1f, 1'b0}) begin
            n_fail++;
            $display("FAIL first_scan got wren=%b busy=%b addr=%h rd=%h v=%b exp 0 0 00 1f 0", ram_wren, busy, ram_addr, rd_addr, rd_valid);
        end
        step();
        n_chk++;
        if ({rd_valid, rd_addr, ram_addr} !== {1'b1, 5'h0, 5'h0}) begin
            n_fail++;
            $display("FAIL first_valid got v=%b rd=%h addr=%h exp 1 00 00", rd_valid, rd_addr, ram_addr);
        end
    endtask

    task automatic test_scan();
        logic [4:0] prev;
        prev = exp_scan();
        for (int i = 0; i < 220; i++) begin
            run = (i < 140) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
            n_chk++;
            if ({ram_addr, rd_addr, rd_valid, ram_wren} !== {exp_scan(), prev, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL scan_step c=%0d got addr=%h rd=%h v=%b wren=%b exp addr=%h rd=%h", cyc, ram_addr, rd_addr, rd_valid, ram_wren, exp_scan(), prev);
            end
            prev = exp_scan();
        end
    endtask

    task automatic test_freeze();
        logic [4:0] hold;
        run = 1'b0;
        hold = exp_scan();
        for (int i = 0; i < 20; i++) begin
            step();
            n_chk++;
            if (ram_addr !== hold) begin
                n_fail++;
                $display("FAIL freeze c=%0d got addr=%h exp %h", cyc, ram_addr, hold);
            end
        end
    endtask

    task automatic test_write();
        logic [4:0] a, s;
        logic [3:0] d;
        for (int k = 0; k < 8; k++) begin
            a = (k == 0) ? 5'h12 : 5'($urandom);
            d = (k == 0) ? 4'hA : 4'($urandom);
            wr_addr = a;
            wr_data = d;
            run = 1'b1;
            if (k % 2 == 1)
                for (int j = 0; j < 2 * TD && (e % TD) != 2; j++) step();
            else
                run = 1'($urandom_range(0, 1));
            wr_req = 1'b1;
            step();
            wr_req = 1'b0;
            if (k % 2 == 0) run = 1'($urandom_range(0, 1));
            n_chk++;
            if ({ram_wren, ram_addr} !== {1'b0, exp_scan()}) begin
                n_fail++;
                $display("FAIL wr_detect k=%0d got wren=%b addr=%h exp 0 %h", k, ram_wren, ram_addr, exp_scan());
            end
            step();
            n_chk++;
            if ({ram_wren, ram_addr, ram_data, busy} !== {1'b1, a, d, 1'b1}) begin
                n_fail++;
                $display("FAIL wr_cycle k=%0d got wren=%b addr=%h data=%h busy=%b exp 1 %h %h 1", k, ram_wren, ram_addr, ram_data, busy, a, d);
            end
            step();
            s = exp_scan();
            n_chk++;
            if ({ram_wren, busy, rd_valid, rd_addr, ram_addr} !== {1'b0, 1'b0, 1'b0, a, s}) begin
                n_fail++;
                $display("FAIL wr_after k=%0d got wren=%b busy=%b v=%b rd=%h addr=%h exp 0 0 0 %h %h", k, ram_wren, busy, rd_valid, rd_addr, ram_addr, a, s);
            end
            step();
            n_chk++;
            if ({ram_wren, rd_valid, rd_addr, ram_addr} !== {1'b0, 1'b1, s, exp_scan()}) begin
                n_fail++;
                $display("FAIL wr_resume k=%0d got wren=%b v=%b rd=%h addr=%h exp 0 1 %h %h", k, ram_wren, rd_valid, rd_addr, ram_addr, s, exp_scan());
            end
        end
    endtask

    task automatic test_clear_write();
        logic [4:0] a, ea;
        logic [3:0] d, ed;
        logic       ew, eb;
        run = 1'b0;
        do_reset();
        a = 5'($urandom);
        d = 4'($urandom);
        wr_addr = a;
        wr_data = d;
        for (int c = 1; c <= 37; c++) begin
            wr_req = (c - 1 >= 5) && (c - 1 != 6);
            step();
            ew = (c <= 32) || (c == 34);
            eb = ew;
            ea = (c <= 32) ? 5'(c - 1) : (c == 34) ? a : 5'h0;
            ed = (c == 34) ? d : 4'h0;
            n_chk++;
            if ({ram_wren, ram_addr, ram_data, busy} !== {ew, ea, ed, eb}) begin
                n_fail++;
                $display("FAIL clear_write c=%0d got wren=%b addr=%h data=%h busy=%b exp %b %h %h %b", c, ram_wren, ram_addr, ram_data, busy, ew, ea, ed, eb);
            end
        end
        wr_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int guard;
        run = 1'b1;
        guard = 0;
        while (exp_scan() != 5'd7 && guard < 400) begin
            step();
            guard++;
        end
        n_chk++;
        if (guard >= 400 || ram_addr !== 5'd7) begin
            n_fail++;
            $display("FAIL reach_addr7 got addr=%h exp 07 guard=%0d", ram_addr, guard);
        end
        do_reset();
        n_chk++;
        if ({ram_wren, ram_addr, busy, rd_valid} !== {1'b0, 5'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset got wren=%b addr=%h busy=%b v=%b exp 0 00 1 0", ram_wren, ram_addr, busy, rd_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if ({ram_wren, ram_addr, busy} !== {1'b1, 5'(i), 1'b1}) begin
                n_fail++;
                $display("FAIL restart_clear i=%0d got wren=%b addr=%h busy=%b exp 1 %h 1", i, ram_wren, ram_addr, busy, 5'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_freeze();
        test_write();
        test_clear_write();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
